acc_cpu_ctrl_p: RTL and testbench

- Parametrised multi-cycle controller for the accumulator CPU datapath (PC, IR, AC, ALU, shared memory bus).
- Extends the 4-instruction fetch/execute controller in three ways:
  - wider opcode space with SUB/AND/JZ/HLT;
  - configurable memory latency, either a fixed wait-count or a mem_ready handshake;
  - a HALT state and an instruction-retire pulse.
- Sits between the IR opcode field and the datapath control lines.

---
 rtl/acc_cpu_pkg.sv | 33 +++
 rtl/acc_mem_wait.sv | 38 +++
 rtl/acc_cpu_ctrl_p.sv | 168 ++++++++++++++++
 tb/tb_acc_cpu_ctrl_p.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared constants for the accumulator CPU controller
//
// Purpose: opcode values, FSM state encoding and ALU select codes used by
// acc_cpu_ctrl_p and its helpers. No ports.

package acc_cpu_pkg;

  // Opcode values (low three bits of the IR opcode field).
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_STA = 3'd2;
  localparam logic [2:0] OP_JMP = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_JZ  = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  // Controller state encoding.
  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEMX  = 3'd3,
    ST_HLT   = 3'd4
  } state_t;

  // ALU select codes.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MEM = 2'b11;

endpackage

// File: rtl/acc_mem_wait.sv
// rtl/acc_mem_wait.sv - memory access completion tracker (wait counter / ready)
//
// Purpose: holds the 4-bit wait counter and reports when the current memory
// access is complete.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   clear         force the counter to 0 (controller not in an access state)
//   enable        controller is in an access state this cycle
//   mem_ready     external completion handshake (used only when USE_READY=1)
//   done          access completes this cycle

module acc_mem_wait #(
  parameter int WAIT_CYCLES = 1,
  parameter int USE_READY   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic mem_ready,
  output logic done
);

  logic [3:0] wcnt;

  assign done = (USE_READY != 0) ? mem_ready : (wcnt == 4'(WAIT_CYCLES));

  // Counter restarts on the completing cycle so the next access (the
  // following state) always begins from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wcnt <= 4'd0;
    end else if (enable) begin
      wcnt <= done ? 4'd0 : wcnt + 4'd1;
    end
  end

endmodule

// File: rtl/acc_cpu_ctrl_p.sv
// rtl/acc_cpu_ctrl_p.sv - multi-cycle fetch/execute controller for the accumulator CPU
//
// Purpose: sequences fetch, execute and memory-operand phases and decodes the
// datapath control strobes from the current state and IR opcode.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   op_code[OPW-1:0]  IR opcode field; codes >= 8 act as NOP
//   ac_zero           accumulator-is-zero flag for JZ
//   mem_ready         access completion handshake (USE_READY=1 only)
//   rd_mem, wr_mem    memory read / write strobes
//   pc_on_adr         PC drives the address bus
//   ir_on_adr         IR address field drives the address bus
//   ld_ir, ld_ac      load IR / AC
//   ld_pc, inc_pc     load PC from IR / increment PC
//   clr_pc            clear PC
//   alu_sel[1:0]      ALU function select
//   instr_done        pulse on the last cycle of each instruction
//   halted            high while stopped in HLT

module acc_cpu_ctrl_p
  import acc_cpu_pkg::*;
#(
  parameter int OPW         = 3,
  parameter int WAIT_CYCLES = 1,
  parameter int USE_READY   = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op_code,
  input  logic           ac_zero,
  input  logic           mem_ready,
  output logic           rd_mem,
  output logic           wr_mem,
  output logic           pc_on_adr,
  output logic           ir_on_adr,
  output logic           ld_ir,
  output logic           ld_ac,
  output logic           ld_pc,
  output logic           inc_pc,
  output logic           clr_pc,
  output logic [1:0]     alu_sel,
  output logic           instr_done,
  output logic           halted
);

  state_t     state;
  state_t     state_nxt;
  logic       in_access;
  logic       acc_done;
  logic [2:0] op_lo;
  logic       op_ext;

  // Any set bit above bit 2 makes the opcode a NOP.
  assign op_lo = op_code[2:0];
  generate
    if (OPW > 3) begin : g_ext
      assign op_ext = |op_code[OPW-1:3];
    end else begin : g_noext
      assign op_ext = 1'b0;
    end
  endgenerate

  assign in_access = (state == ST_FETCH) || (state == ST_MEMX);

  acc_mem_wait #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .USE_READY   (USE_READY)
  ) u_mem_wait (
    .clk       (clk),
    .reset     (reset),
    .clear     (!in_access),
    .enable    (in_access),
    .mem_ready (mem_ready),
    .done      (acc_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_mem     = 1'b0;
    wr_mem     = 1'b0;
    pc_on_adr  = 1'b0;
    ir_on_adr  = 1'b0;
    ld_ir      = 1'b0;
    ld_ac      = 1'b0;
    ld_pc      = 1'b0;
    inc_pc     = 1'b0;
    clr_pc     = 1'b0;
    alu_sel    = ALU_ADD;
    instr_done = 1'b0;
    halted     = 1'b0;

    case (state)
      ST_RST: begin
        clr_pc    = 1'b1;
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        pc_on_adr = 1'b1;
        rd_mem    = 1'b1;
        if (acc_done) begin
          ld_ir     = 1'b1;
          inc_pc    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_nxt  = ST_FETCH;
        instr_done = 1'b1;
        if (!op_ext) begin
          case (op_lo)
            OP_ADD: begin
              ld_ac   = 1'b1;
              alu_sel = ALU_ADD;
            end
            OP_SUB: begin
              ld_ac   = 1'b1;
              alu_sel = ALU_SUB;
            end
            OP_AND: begin
              ld_ac   = 1'b1;
              alu_sel = ALU_AND;
            end
            OP_JMP: ld_pc = 1'b1;
            OP_JZ:  ld_pc = ac_zero;
            OP_LDA, OP_STA: begin
              instr_done = 1'b0;
              state_nxt  = ST_MEMX;
            end
            OP_HLT: state_nxt = ST_HLT;
            default: ;
          endcase
        end
      end

      ST_MEMX: begin
        ir_on_adr = 1'b1;
        if (!op_ext && op_lo == OP_LDA) begin
          rd_mem  = 1'b1;
          alu_sel = ALU_MEM;
          ld_ac   = acc_done;
        end else if (!op_ext && op_lo == OP_STA) begin
          wr_mem = 1'b1;
        end
        // IR is stable here, so only LDA/STA reach this state; any other
        // code simply finishes the access without strobes.
        if (acc_done) begin
          instr_done = 1'b1;
          state_nxt  = ST_FETCH;
        end
      end

      ST_HLT: halted = 1'b1;

      default: state_nxt = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_acc_cpu_ctrl_p.sv
// tb/tb_acc_cpu_ctrl_p.sv - scoreboard bench for acc_cpu_ctrl_p over three configurations

module tb_acc_cpu_ctrl_p;

  typedef struct {
    int cycles;
    int rd;
    int wr;
    int pca;
    int ira;
    int ldir_pos;
    int ldac;
    int alu;
    int ldpc;
  } exp_t;

  typedef struct {
    int op;
    int az;
    int f;
    int m;
    int abort;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int g, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0d expected=%0d", name, g, act, exp);
    end
  endtask

  // g=0: fixed wait W=2; g=1: fixed wait W=0; g=2: mem_ready handshake.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int UR = (g == 2) ? 1 : 0;
    localparam int WC = (g == 0) ? 2 : 0;

    logic       reset;
    logic [3:0] op_code;
    logic       ac_zero;
    logic       mem_ready;
    logic       rd_mem, wr_mem, pc_on_adr, ir_on_adr, ld_ir, ld_ac, ld_pc;
    logic       inc_pc, clr_pc, instr_done, halted;
    logic [1:0] alu_sel;
    logic [11:0] strb;
    logic       active;
    exp_t       exp_q[$];

    int a_cyc, a_rd, a_wr, a_pca, a_ira, a_ldir, a_ldir_pos;
    int a_ldac, a_ldac_pos, a_alu, a_ldpc, a_incmis;

    assign strb = {rd_mem, wr_mem, pc_on_adr, ir_on_adr, ld_ir, ld_ac, ld_pc,
                   inc_pc, clr_pc, instr_done, alu_sel};

    acc_cpu_ctrl_p #(
      .OPW         (4),
      .WAIT_CYCLES (WC),
      .USE_READY   (UR)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .op_code    (op_code),
      .ac_zero    (ac_zero),
      .mem_ready  (mem_ready),
      .rd_mem     (rd_mem),
      .wr_mem     (wr_mem),
      .pc_on_adr  (pc_on_adr),
      .ir_on_adr  (ir_on_adr),
      .ld_ir      (ld_ir),
      .ld_ac      (ld_ac),
      .ld_pc      (ld_pc),
      .inc_pc     (inc_pc),
      .clr_pc     (clr_pc),
      .alu_sel    (alu_sel),
      .instr_done (instr_done),
      .halted     (halted)
    );

    // Monitor: accumulates what the DUT did during one instruction and
    // compares against the scoreboard entry when instr_done appears.
    always @(negedge clk) begin : mon
      exp_t e;
      if (active) begin
        chk("rd_wr_exclusive", g, int'(rd_mem & wr_mem), 0);
        chk("adr_exclusive", g, int'(pc_on_adr & ir_on_adr), 0);
        chk("running_not_halted", g, int'(halted | clr_pc), 0);
        if (rd_mem)    a_rd++;
        if (wr_mem)    a_wr++;
        if (pc_on_adr) a_pca++;
        if (ir_on_adr) a_ira++;
        if (ld_pc)     a_ldpc++;
        if (ld_ir != inc_pc) a_incmis++;
        if (ld_ir) begin
          a_ldir++;
          a_ldir_pos = a_cyc;
        end
        if (ld_ac) begin
          a_ldac++;
          a_ldac_pos = a_cyc;
          a_alu = int'(alu_sel);
        end
        a_cyc++;
        if (instr_done) begin
          chk("sb_has_entry", g, int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cpi", g, a_cyc, e.cycles);
            chk("rd_mem_cycles", g, a_rd, e.rd);
            chk("wr_mem_cycles", g, a_wr, e.wr);
            chk("pc_on_adr_cycles", g, a_pca, e.pca);
            chk("ir_on_adr_cycles", g, a_ira, e.ira);
            chk("ld_ir_count", g, a_ldir, 1);
            chk("ld_ir_cycle", g, a_ldir_pos, e.ldir_pos);
            chk("inc_pc_with_ld_ir", g, a_incmis, 0);
            chk("ld_ac_count", g, a_ldac, e.ldac);
            if (e.ldac != 0) begin
              chk("ld_ac_cycle", g, a_ldac_pos, e.cycles - 1);
              chk("alu_sel", g, a_alu, e.alu);
            end
            chk("ld_pc_count", g, a_ldpc, e.ldpc);
          end
        end
      end
      if (!active || instr_done) begin
        a_cyc = 0; a_rd = 0; a_wr = 0; a_pca = 0; a_ira = 0; a_ldir = 0;
        a_ldir_pos = -1; a_ldac = 0; a_ldac_pos = -1; a_alu = -1; a_ldpc = 0;
        a_incmis = 0;
      end
    end

    // Driver: issues instructions, plays memory timing, pushes expectations.
    initial begin : drv
      item_t items[$];
      item_t it;
      exp_t  e;
      int    fc, mc, k;
      bit    fin, mem;

      reset = 1'b1; op_code = 4'd0; ac_zero = 1'b0; mem_ready = 1'b0; active = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_outputs", g, int'(strb), 8);
      chk("reset_halted", g, int'(halted), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_release_clr_pc", g, int'(clr_pc), 1);
      @(posedge clk); #1;

      // Directed program, then random, then HLT.
      items.push_back('{0, 0, 4, 0, 0});   // ADD (4 not-ready FETCH cycles when UR)
      items.push_back('{1, 0, 1, 2, 0});   // LDA
      items.push_back('{2, 0, 0, 2, 0});   // STA
      items.push_back('{5, 1, 2, 0, 0});   // JZ taken
      items.push_back('{5, 0, 0, 0, 0});   // JZ not taken
      items.push_back('{4, 0, 1, 0, 0});   // SUB
      items.push_back('{6, 0, 3, 0, 0});   // AND
      items.push_back('{3, 0, 0, 0, 0});   // JMP
      items.push_back('{9, 1, 1, 0, 0});   // NOP (code >= 8)
      items.push_back('{15, 0, 0, 0, 0});  // NOP
      if (g != 1) items.push_back('{2, 0, 1, 3, 1});  // STA aborted by reset
      items.push_back('{0, 0, 0, 0, 0});   // ADD right after abort
      for (int i = 0; i < 40; i++) begin
        it.op = int'($urandom_range(0, 15));
        if (it.op == 7) it.op = 1;
        it.az = int'($urandom_range(0, 1));
        it.f  = int'($urandom_range(0, 4));
        it.m  = int'($urandom_range(0, 4));
        it.abort = 0;
        items.push_back(it);
      end
      items.push_back('{7, 0, 2, 0, 0});   // HLT

      foreach (items[i]) begin
        it  = items[i];
        fc  = (UR != 0) ? it.f + 1 : WC + 1;
        mc  = (UR != 0) ? it.m + 1 : WC + 1;
        mem = (it.op == 1) || (it.op == 2);
        e.cycles   = fc + 1 + (mem ? mc : 0);
        e.rd       = fc + ((it.op == 1) ? mc : 0);
        e.wr       = (it.op == 2) ? mc : 0;
        e.pca      = fc;
        e.ira      = mem ? mc : 0;
        e.ldir_pos = fc - 1;
        e.ldac     = (it.op == 0 || it.op == 1 || it.op == 4 || it.op == 6) ? 1 : 0;
        e.alu      = (it.op == 0) ? 0 : (it.op == 4) ? 1 : (it.op == 6) ? 2 : 3;
        e.ldpc     = (it.op == 3) ? 1 : (it.op == 5) ? it.az : 0;
        op_code = 4'(it.op);
        ac_zero = (it.az != 0);
        if (it.abort == 0) begin
          exp_q.push_back(e);
          active = 1'b1;
        end else begin
          active = 1'b0;
        end
        k = 0;
        fin = 1'b0;
        while (!fin) begin
          if (UR != 0) mem_ready = (k == fc - 1) || (mem && k == fc + mc);
          else         mem_ready = 1'($urandom_range(0, 1));
          if (it.abort != 0 && k == fc + 2) begin
            reset = 1'b1;
            @(negedge clk);
            chk("abort_pre_wr_mem", g, int'(wr_mem), 1);
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("abort_clr_pc", g, int'(clr_pc), 1);
            chk("abort_wr_mem", g, int'(wr_mem), 0);
            chk("abort_ir_on_adr", g, int'(ir_on_adr), 0);
            @(posedge clk); #1;
            fin = 1'b1;
          end else begin
            @(negedge clk);
            if (instr_done) fin = 1'b1;
            k++;
            if (k > 80) begin
              chk("instr_timeout", g, k, 0);
              fin = 1'b1;
            end
            @(posedge clk); #1;
          end
        end
      end
      active = 1'b0;

      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        chk("hlt_halted", g, int'(halted), 1);
        chk("hlt_strobes", g, int'(strb), 0);
        @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("hlt_reset_clr_pc", g, int'(clr_pc), 1);
      chk("hlt_reset_halted", g, int'(halted), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_reset_fetch", g, int'(pc_on_adr & rd_mem), 1);
      chk("sb_drained", g, exp_q.size(), 0);
      done_cnt++;
    end
  end

  initial begin
    for (int c = 0; c < 20000 && done_cnt < 3; c++) @(posedge clk);
    if (done_cnt < 3) chk("global_timeout", 0, done_cnt, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
